poly_alu_seq: RTL and testbench

- Command-driven sequencer for the polynomial ALU datapath; streams one polynomial (N_COEFF coefficients) through it per command.
- Generates coefficient-memory read addresses and the ALU enable.
- Holds the ALU mode word stable for the whole command.
- Uses the ALU valid to generate write-back addresses, then signals done.
- Sits between the top-level instruction decoder and one ALU plus its coefficient RAM ports.

---
 rtl/poly_alu_seq.sv | 136 +++++++++++++
 tb/tb_poly_alu_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_alu_seq.sv
// Command sequencer for the polynomial ALU. It streams N_COEFF operand reads per
// command, lines the ALU enable up with RAM latency, and counts ALU results into the result RAM.
module poly_alu_seq #(
    parameter int N_COEFF = 256,
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 1,
    parameter int ALU_LAT = 5,
    parameter int TMO_W   = 4
) (
    input  logic              poly_clk,
    input  logic              poly_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_mode,
    input  logic [ADDR_W-1:0] cmd_rd_base_a,
    input  logic [ADDR_W-1:0] cmd_rd_base_b,
    input  logic [ADDR_W-1:0] cmd_wr_base,
    input  logic              issue_hold,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    output logic              alu_enable,
    output logic [9:0]        alu_mode,
    input  logic              alu_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N_COEFF - 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_LAT + ALU_LAT + 2);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  wr_cnt;
    logic [ADDR_W-1:0] base_a_q;
    logic [ADDR_W-1:0] base_b_q;
    logic [ADDR_W-1:0] wr_base_q;
    logic [9:0]        mode_q;
    logic [MEM_LAT-1:0] en_pipe;
    logic [TMO_W-1:0]  wdog;
    logic              err_q;

    logic accept;
    logic issue_fire;
    logic wr_fire;
    logic last_rd;
    logic last_wr;
    logic wdog_trip;
    logic spurious;

    always_comb begin
        accept     = (state == IDLE) && cmd_valid;
        issue_fire = (state == ISSUE) && !issue_hold;
        wr_fire    = (state != IDLE) && alu_valid;
        last_rd    = issue_fire && (rd_cnt == LAST_IDX);
        last_wr    = wr_fire && (wr_cnt == LAST_IDX);
        wdog_trip  = (state == DRAIN) && !alu_valid && ((wdog + TMO_W'(1)) == TMO_LIMIT);
        spurious   = (state == IDLE) && alu_valid;
    end

    always_ff @(posedge poly_clk or posedge poly_rst) begin
        if (poly_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   if (last_rd) state_nxt = DRAIN;
            DRAIN:   if (last_wr || wdog_trip) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The enable chain runs regardless of state so the final reads still reach the ALU after ISSUE ends.
    always_ff @(posedge poly_clk or posedge poly_rst) begin
        if (poly_rst) begin
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            base_a_q  <= '0;
            base_b_q  <= '0;
            wr_base_q <= '0;
            mode_q    <= '0;
            en_pipe   <= '0;
            wdog      <= '0;
            err_q     <= 1'b0;
        end else begin
            en_pipe <= (en_pipe << 1) | MEM_LAT'(issue_fire);
            if (accept) begin
                mode_q    <= cmd_mode;
                base_a_q  <= cmd_rd_base_a;
                base_b_q  <= cmd_rd_base_b;
                wr_base_q <= cmd_wr_base;
                rd_cnt    <= '0;
                wr_cnt    <= '0;
            end else begin
                if (issue_fire) rd_cnt <= rd_cnt + CNT_W'(1);
                if (wr_fire)    wr_cnt <= wr_cnt + CNT_W'(1);
            end
            if ((state == DRAIN) && !alu_valid) begin
                wdog <= wdog + TMO_W'(1);
            end else begin
                wdog <= '0;
            end
            if (spurious || wdog_trip) err_q <= 1'b1;
        end
    end

    // cmd_ready is gated by reset so every output reads 0 while reset is held.
    always_comb begin
        cmd_ready  = (state == IDLE) && !poly_rst;
        rd_en      = issue_fire;
        rd_addr_a  = issue_fire ? (base_a_q + rd_cnt[ADDR_W-1:0]) : '0;
        rd_addr_b  = issue_fire ? (base_b_q + rd_cnt[ADDR_W-1:0]) : '0;
        alu_enable = en_pipe[MEM_LAT-1];
        alu_mode   = mode_q;
        wr_en      = wr_fire;
        wr_addr    = wr_fire ? (wr_base_q + wr_cnt[ADDR_W-1:0]) : '0;
        busy       = (state != IDLE);
        done       = (state == DONE);
        err        = err_q;
    end

endmodule

// File: tb/tb_poly_alu_seq.sv
// Self-checking bench for poly_alu_seq: a directed vector table, randomized commands,
// and hand-written reset and spurious-valid sequences, with a delay-line ALU model.
module tb_poly_alu_seq;

    localparam int N_COEFF   = 256;
    localparam int ADDR_W    = 8;
    localparam int MEM_LAT   = 1;
    localparam int ALU_LAT   = 5;
    localparam int TMO_W     = 4;
    localparam int DRAIN_TMO = MEM_LAT + ALU_LAT + 2;

    logic              poly_clk;
    logic              poly_rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [9:0]        cmd_mode;
    logic [ADDR_W-1:0] cmd_rd_base_a;
    logic [ADDR_W-1:0] cmd_rd_base_b;
    logic [ADDR_W-1:0] cmd_wr_base;
    logic              issue_hold;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic              alu_enable;
    logic [9:0]        alu_mode;
    logic              alu_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              busy;
    logic              done;
    logic              err;

    poly_alu_seq #(
        .N_COEFF(N_COEFF), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT),
        .ALU_LAT(ALU_LAT), .TMO_W(TMO_W)
    ) dut (
        .poly_clk(poly_clk), .poly_rst(poly_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_rd_base_a(cmd_rd_base_a), .cmd_rd_base_b(cmd_rd_base_b),
        .cmd_wr_base(cmd_wr_base), .issue_hold(issue_hold),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .alu_enable(alu_enable), .alu_mode(alu_mode), .alu_valid(alu_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        logic [7:0] base_a;
        logic [7:0] base_b;
        logic [7:0] wr_base;
        logic [9:0] mode;
        int         hold_start;
        int         hold_len;
        int         suppress_after;
        bit         keep_valid;
        int         exp_done;
    } vec_t;

    vec_t vecs[6];

    int vec_count = 0;
    int miss_count = 0;
    logic [ALU_LAT-1:0] alu_hist = '0;
    bit hold_pat[0:1023];
    bit err_exp = 1'b0;

    initial poly_clk = 1'b0;
    always #5 poly_clk = ~poly_clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish, required finish before 1000000");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit cv, input logic [9:0] md, input logic [7:0] ba,
                                 input logic [7:0] bb, input logic [7:0] wb,
                                 input bit hold, input bit valid);
        @(negedge poly_clk);
        cmd_valid     = cv;
        cmd_mode      = md;
        cmd_rd_base_a = ba;
        cmd_rd_base_b = bb;
        cmd_wr_base   = wb;
        issue_hold    = hold;
        alu_valid     = valid;
        #1;
    endtask

    // ALU stand-in: a result appears exactly ALU_LAT cycles after each enable.
    task automatic shiftAlu();
        alu_hist = {alu_hist[ALU_LAT-2:0], alu_enable};
    endtask

    function automatic int modelDone(input int suppress_after);
        int reads = 0;
        for (int n = 1; n < 1024; n++) begin
            if (!hold_pat[n]) reads++;
            if (reads == N_COEFF)
                return (suppress_after < N_COEFF) ? n + 1 + DRAIN_TMO : n + MEM_LAT + ALU_LAT + 1;
        end
        return 1023;
    endfunction

    task automatic idleCycles(input int k, input bit spurious);
        bit v;
        for (int i = 0; i < k; i++) begin
            v = alu_hist[ALU_LAT-1] | (spurious && i == 0);
            applyStimulus(1'b0, '0, '0, '0, '0, 1'b0, v);
            checkOutput("idle wr_en", wr_en, 0);
            checkOutput("idle busy", busy, 0);
            checkOutput("idle cmd_ready", cmd_ready, 1);
            checkOutput("idle done", done, 0);
            checkOutput("idle err", err, err_exp);
            if (v) err_exp = 1'b1;
            shiftAlu();
        end
    endtask

    task automatic resetAbortCheck();
        poly_rst = 1'b1;
        #1;
        checkOutput("rst rd_en", rd_en, 0);
        checkOutput("rst alu_enable", alu_enable, 0);
        checkOutput("rst wr_en", wr_en, 0);
        checkOutput("rst busy", busy, 0);
        checkOutput("rst done", done, 0);
        checkOutput("rst cmd_ready", cmd_ready, 0);
        checkOutput("rst alu_mode", alu_mode, 0);
        checkOutput("rst rd_addr_a", rd_addr_a, 0);
        checkOutput("rst err", err, 0);
        alu_hist = '0;
        err_exp  = 1'b0;
        @(negedge poly_clk);
        cmd_valid = 1'b0;
        alu_valid = 1'b0;
        issue_hold = 1'b0;
        @(negedge poly_clk);
        poly_rst = 1'b0;
    endtask

    task automatic runCmd(input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] wb,
                          input logic [9:0] md, input bit keep_valid, input int suppress_after,
                          input int exp_done, input int abort_at);
        int reads = 0;
        int writes = 0;
        bit v;
        bit wdog_exp;
        wdog_exp = (suppress_after < N_COEFF);
        v = alu_hist[ALU_LAT-1];
        applyStimulus(1'b1, md, ba, bb, wb, 1'b0, v);
        checkOutput("accept cmd_ready", cmd_ready, 1);
        checkOutput("accept busy", busy, 0);
        shiftAlu();
        for (int n = 1; n <= exp_done; n++) begin
            v = alu_hist[ALU_LAT-1] && (writes < suppress_after);
            if (keep_valid)
                applyStimulus(1'b1, ~md, ~ba, ~bb, ~wb, hold_pat[n], v);
            else
                applyStimulus(1'b0, md, ba, bb, wb, hold_pat[n], v);
            checkOutput("rd_en", rd_en, !hold_pat[n] && reads < N_COEFF);
            if (rd_en) begin
                checkOutput("rd_addr_a", rd_addr_a, (int'(ba) + reads) % 256);
                checkOutput("rd_addr_b", rd_addr_b, (int'(bb) + reads) % 256);
                reads++;
            end
            checkOutput("wr_en", wr_en, v);
            if (wr_en) begin
                checkOutput("wr_addr", wr_addr, (int'(wb) + writes) % 256);
                writes++;
            end
            checkOutput("alu_mode", alu_mode, md);
            checkOutput("busy", busy, 1);
            checkOutput("cmd_ready", cmd_ready, 0);
            if (wdog_exp && n == exp_done) err_exp = 1'b1;
            checkOutput("err", err, err_exp);
            checkOutput("done", done, n == exp_done);
            shiftAlu();
            if (n == abort_at) begin
                resetAbortCheck();
                return;
            end
        end
        checkOutput("read count", reads, N_COEFF);
        checkOutput("write count", writes, wdog_exp ? suppress_after : N_COEFF);
    endtask

    initial begin
        poly_rst = 1'b1;
        cmd_valid = 1'b0; cmd_mode = '0; cmd_rd_base_a = '0; cmd_rd_base_b = '0;
        cmd_wr_base = '0; issue_hold = 1'b0; alu_valid = 1'b0;
        for (int i = 0; i < 1024; i++) hold_pat[i] = 1'b0;

        vecs[0] = '{8'h00, 8'h40, 8'h80, 10'h3C1,  0,  0, 256, 1'b0, 263};
        vecs[1] = '{8'h10, 8'h20, 8'h30, 10'h155, 50, 10, 256, 1'b0, 273};
        vecs[2] = '{8'hF0, 8'h7F, 8'hFF, 10'h2AA,  0,  0, 256, 1'b0, 263};
        vecs[3] = '{8'h11, 8'h22, 8'h33, 10'h0F0,  0,  0, 100, 1'b0, 265};
        vecs[4] = '{8'h05, 8'h06, 8'h07, 10'h111,  0,  0, 256, 1'b1, 263};
        vecs[5] = '{8'h08, 8'h09, 8'h0A, 10'h222,  0,  0, 256, 1'b0, 263};

        #1;
        checkOutput("reset cmd_ready", cmd_ready, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset rd_en", rd_en, 0);
        checkOutput("reset alu_enable", alu_enable, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset err", err, 0);
        checkOutput("reset alu_mode", alu_mode, 0);
        @(negedge poly_clk);
        @(negedge poly_clk);
        poly_rst = 1'b0;
        idleCycles(2, 1'b0);

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 1024; i++)
                hold_pat[i] = (i >= vecs[v].hold_start) && (i < vecs[v].hold_start + vecs[v].hold_len);
            $display("[TB] table vector %0d", v);
            runCmd(vecs[v].base_a, vecs[v].base_b, vecs[v].wr_base, vecs[v].mode,
                   vecs[v].keep_valid, vecs[v].suppress_after, vecs[v].exp_done, -1);
        end

        for (int r = 0; r < 4; r++) begin
            logic [7:0] ba, bb, wb;
            logic [9:0] md;
            ba = 8'($urandom_range(0, 255));
            bb = 8'($urandom_range(0, 255));
            wb = 8'($urandom_range(0, 255));
            md = 10'($urandom_range(0, 1023));
            hold_pat[0] = 1'b0;
            for (int i = 1; i < 1024; i++) hold_pat[i] = ($urandom_range(0, 7) == 0);
            $display("[TB] random command %0d", r);
            runCmd(ba, bb, wb, md, 1'b0, N_COEFF, modelDone(N_COEFF), -1);
            idleCycles(int'($urandom_range(0, 3)), 1'b0);
        end

        for (int i = 0; i < 1024; i++) hold_pat[i] = 1'b0;
        $display("[TB] reset during issue");
        runCmd(8'h33, 8'h44, 8'h55, 10'h0AB, 1'b0, N_COEFF, 263, 31);
        idleCycles(12, 1'b0);

        runCmd(8'hFE, 8'h01, 8'hFF, 10'h1C7, 1'b0, N_COEFF, 263, -1);

        $display("[TB] spurious valid in idle");
        idleCycles(3, 1'b1);
        checkOutput("sticky err", err, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
